spi_master: RTL
===============

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have port clk, input, 1: single system clock; all state on rising edge; also used as the serial bit clock.
REQ-002 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port cmd_valid, input, 1: command request.
REQ-004 SHALL have port cmd_ready, output, 1: high only in IDLE; command accepted when cmd_valid & cmd_ready.
REQ-005 SHALL have port cmd_op, input, 2: 00 write addr, 01 write data, 10 read addr, 11 read data.
REQ-006 SHALL have port cmd_data, input, 8: address or data payload; ignored for op 11.
REQ-007 SHALL have port SS_n, output, 1: active-low slave select.
REQ-008 SHALL have port MOSI, output, 1: serial data to slave, MSB first.
REQ-009 SHALL have port MISO, input, 1: serial data from slave.
REQ-010 SHALL have port rd_data, output, 8: last read byte, held until next read completes.
REQ-011 SHALL have port rd_valid, output, 1: one-cycle pulse when rd_data updates.
REQ-012 SHALL have port err, output, 1: one-cycle pulse on rejected command (see REQ-026).

Function
REQ-013 SHALL implement states IDLE, MODE, SHIFT, TURN, READ, DONE.
REQ-014 SHALL latch frame = {cmd_op, cmd_data} (10 bits) on acceptance; cmd_ready drops the following cycle.
REQ-015 SHALL, in MODE (cycle after acceptance), drive SS_n=0 and MOSI=cmd_op[1] for one cycle.
REQ-016 SHALL, in SHIFT, drive frame[9] down to frame[0] on MOSI, one bit per cycle, 10 cycles.
REQ-017 SHALL, for ops 00/01/10, go SHIFT -> DONE; SS_n low for exactly 11 cycles.
REQ-018 SHALL, for op 11, go SHIFT -> TURN (2 cycles, MOSI=0) -> READ (8 cycles) -> DONE; SS_n low for exactly 21 cycles.
REQ-019 SHALL, in READ, sample MISO each rising edge into a shift register, MSB first.
REQ-020 SHALL, in DONE, drive SS_n=1 for one cycle, update rd_data and pulse rd_valid (op 11 only), then return to IDLE.
REQ-021 SHALL guarantee SS_n high for at least 2 cycles between frames (DONE + IDLE).
REQ-022 SHALL drive MOSI=0 whenever SS_n=1.
REQ-023 SHALL ignore cmd_valid while cmd_ready=0; no queuing.
REQ-024 SHALL use a 5-bit bit counter that saturates never; reloaded on each state entry.

Reset
REQ-025 SHALL, on rst (including mid-frame), immediately force IDLE, SS_n=1, MOSI=0, cmd_ready=1 after release, rd_data=8'h00, rd_valid=0, err=0, read-address-seen flag=0; aborted frame produces no rd_valid.

Configuration
REQ-026 SHALL, with SPI_MASTER_SEQ_CHECK_EN defined, track a read-address-seen flag (set by accepted op 10, cleared by completed op 11); an op 11 accepted with flag=0 is not transmitted (SS_n stays 1), err pulses the cycle after acceptance, return to IDLE.
REQ-027 SHALL, without SPI_MASTER_SEQ_CHECK_EN, transmit every op unconditionally and tie err to 0.

Structure
REQ-028 SHALL place op enum (OP_WR_ADDR, OP_WR_DATA, OP_RD_ADDR, OP_RD_DATA), state enum, and constants FRAME_W=10, DATA_W=8, TURN_CYC=2 in package spi_pkg.
REQ-029 SHALL factor the load/shift-out/shift-in register into one sub-module spi_master_shreg.

Verification
REQ-030 SHALL cover: rst then op 00 data 8'hA5 -> SS_n low 11 cycles, MOSI = 0,0,0,1,0,1,0,0,1,0,1, then SS_n=1.
REQ-031 SHALL cover: op 10 data 8'h3C then op 11 with slave model returning 8'h96 on MISO -> SS_n low 21 cycles, rd_data=8'h96, rd_valid one pulse in DONE.
REQ-032 SHALL cover: cmd_valid held high during a frame -> exactly one command accepted per frame, SS_n high >=2 cycles between frames.
REQ-033 SHALL cover: rst asserted at bit 5 of op 11 -> SS_n=1 and MOSI=0 same cycle, no rd_valid, rd_data=8'h00.
REQ-034 SHALL cover: with SPI_MASTER_SEQ_CHECK_EN, op 11 after reset without op 10 -> err pulse, SS_n never low; without macro -> frame transmitted, err=0.
REQ-035 SHALL cover: back-to-back ops 00,01,10,11 to SPI slave+RAM model -> read returns the written byte.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master: command opcodes, FSM states and frame geometry.
package spi_pkg;

    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MODE,
        ST_SHIFT,
        ST_TURN,
        ST_READ,
        ST_DONE
    } state_e;

    localparam int unsigned FRAME_W  = 10;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned TURN_CYC = 2;
    localparam int unsigned CNT_W    = 5;

endpackage

// File: rtl/spi_master_shreg.sv
// Frame shift register: parallel load of {op, payload}, MSB-first shift-out, LSB-side shift-in of MISO.
module spi_master_shreg
    import spi_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               shift,
    input  logic [FRAME_W-1:0] din,
    input  logic               sin,
    output logic               sout,
    output logic [DATA_W-1:0]  rx_byte
);

    logic [FRAME_W-1:0] q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {q[FRAME_W-2:0], sin};
        end
    end

    assign sout    = q[FRAME_W-1];
    // Byte as it will stand after the current shift-in, so the last READ cycle can capture it directly.
    assign rx_byte = {q[DATA_W-2:0], sin};

endmodule

// File: rtl/spi_master.sv
// Command-driven SPI master; clk doubles as the serial bit clock.
// Define SPI_MASTER_SEQ_CHECK_EN to reject read-data commands not preceded by a read-address command.
module spi_master
    import spi_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              SS_n,
    output logic              MOSI,
    input  logic              MISO,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              err
);

    state_e             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_load;
    op_e                op_q;
    logic               accept, start, reject, last_read;
    logic               sh_shift, sh_out;
    logic [DATA_W-1:0]  rx_byte;

    assign cmd_ready = (state == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign last_read = (state == ST_READ) && (cnt == '0);
    assign start     = accept && !reject;

`ifdef SPI_MASTER_SEQ_CHECK_EN
    logic rd_addr_seen, err_q;

    assign reject = accept && (cmd_op == OP_RD_DATA) && !rd_addr_seen;
    assign err    = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr_seen <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            err_q <= reject;
            if (start && (cmd_op == OP_RD_ADDR)) begin
                rd_addr_seen <= 1'b1;
            end else if (last_read) begin
                rd_addr_seen <= 1'b0;
            end
        end
    end
`else
    assign reject = 1'b0;
    assign err    = 1'b0;
`endif

    spi_master_shreg u_shreg (
        .clk     (clk),
        .rst     (rst),
        .load    (start),
        .shift   (sh_shift),
        .din     ({cmd_op, cmd_data}),
        .sin     (MISO),
        .sout    (sh_out),
        .rx_byte (rx_byte)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            op_q     <= OP_WR_ADDR;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= (state_next != state) ? cnt_load : cnt - CNT_W'(1);
            rd_valid <= last_read;
            if (start) begin
                op_q <= op_e'(cmd_op);
            end
            if (last_read) begin
                rd_data <= rx_byte;
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_load   = '0;
        sh_shift   = 1'b0;
        SS_n       = 1'b1;
        MOSI       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_MODE;
            end
            ST_MODE: begin
                SS_n       = 1'b0;
                MOSI       = sh_out;
                state_next = ST_SHIFT;
                cnt_load   = CNT_W'(FRAME_W - 1);
            end
            ST_SHIFT: begin
                SS_n     = 1'b0;
                MOSI     = sh_out;
                sh_shift = 1'b1;
                if (cnt == '0) begin
                    if (op_q == OP_RD_DATA) begin
                        state_next = ST_TURN;
                        cnt_load   = CNT_W'(TURN_CYC - 1);
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_TURN: begin
                SS_n = 1'b0;
                if (cnt == '0) begin
                    state_next = ST_READ;
                    cnt_load   = CNT_W'(DATA_W - 1);
                end
            end
            ST_READ: begin
                SS_n     = 1'b0;
                sh_shift = 1'b1;
                if (cnt == '0) state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule
